// File: rtl/typedefs.sv
// Shared types for the basic CPU: opcodes and the controller's phase states.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Opcodes whose result is taken from memory/ALU into the accumulator.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction sequencer: steps an 8-phase cycle per instruction and decodes
// opcode/zero into datapath strobes.
//
// state      | meaning
// INST_ADDR  | instruction address on the bus
// INST_FETCH | read instruction from memory
// INST_LOAD  | load IR
// IDLE       | IR load held while the opcode settles
// OP_ADDR    | PC increment, or halt on HLT
// OP_FETCH   | operand read for accumulator ops
// ALU_OP     | result capture begins, SKZ test, jump, store drive
// STORE      | capture completes, memory write for STO
// HALTED     | terminal, left only by reset
module cpu_controller
  import typedefs::*;
(
  input  logic    clk,
  input  logic    rst_,
  input  logic    en,
  input  opcode_t opcode,
  input  logic    zero,
  output logic    mem_rd,
  output logic    mem_wr,
  output logic    load_ir,
  output logic    load_ac,
  output logic    load_pc,
  output logic    inc_pc,
  output logic    data_e,
  output logic    halt,
  output state_t  phase
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_aluop;
  logic   w_is_sto;
  logic   w_is_jmp;

  assign w_aluop  = is_aluop(opcode);
  assign w_is_sto = (opcode == STO);
  assign w_is_jmp = (opcode == JMP);
  assign phase    = r_state;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= INST_ADDR;
    else       r_state <= w_state_nxt;
  end

  // Invalid encodings recover regardless of en; HALTED ignores en entirely.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      INST_ADDR:  if (en) w_state_nxt = INST_FETCH;
      INST_FETCH: if (en) w_state_nxt = INST_LOAD;
      INST_LOAD:  if (en) w_state_nxt = IDLE;
      IDLE:       if (en) w_state_nxt = OP_ADDR;
      OP_ADDR:    if (en) w_state_nxt = (opcode == HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   if (en) w_state_nxt = ALU_OP;
      ALU_OP:     if (en) w_state_nxt = STORE;
      STORE:      if (en) w_state_nxt = INST_ADDR;
      HALTED:     w_state_nxt = HALTED;
      default:    w_state_nxt = INST_ADDR;
    endcase
  end

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    data_e  = 1'b0;
    halt    = 1'b0;
    unique case (r_state)
      INST_ADDR:  ;
      INST_FETCH: mem_rd = 1'b1;
      INST_LOAD, IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = (opcode != HLT);
        halt   = (opcode == HLT);
      end
      OP_FETCH:   mem_rd = w_aluop;
      ALU_OP: begin
        mem_rd  = w_aluop;
        load_ac = w_aluop;
        load_pc = w_is_jmp;
        data_e  = w_is_sto;
        inc_pc  = (opcode == SKZ) && zero;
      end
      STORE: begin
        mem_rd  = w_aluop;
        load_ac = w_aluop;
        load_pc = w_is_jmp;
        data_e  = w_is_sto;
        mem_wr  = w_is_sto;
      end
      HALTED:     halt = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction sequencer for the basic CPU. It steps a fixed 8-phase cycle per instruction and decodes the registered `opcode_t` together with the ALU `zero` flag into datapath strobes. These strobes are memory read/write, IR/PC/accumulator loads, PC increment, data-bus enable and halt. It is the initiating side of the ALU/datapath control interface: the ALU consumes the opcode and operands, and this block decides when each result is captured.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; the FSM updates on posedge.
- `rst_`  in  1  asynchronous, active-low reset.
- `en`  in  1  phase-advance enable; when low the FSM holds its state and all outputs hold.
- `opcode`  in  `opcode_t`  current instruction from the IR.
- `zero`  in  1  ALU accumulator-is-zero flag.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `load_ir`  out  1  instruction register load.
- `load_ac`  out  1  accumulator load.
- `load_pc`  out  1  PC parallel load (jump).
- `inc_pc`  out  1  PC increment.
- `data_e`  out  1  accumulator drives the data bus.
- `halt`  out  1  CPU halted; sticky.
- `phase`  out  `state_t`  current FSM state, for debug and the bench.

## Operation
- States, in fixed order: `INST_ADDR`, `INST_FETCH`, `INST_LOAD`, `IDLE`, `OP_ADDR`, `OP_FETCH`, `ALU_OP`, `STORE`, then wrap to `INST_ADDR`. There is also a terminal state, `HALTED`.
- Each enabled posedge advances one state.
- In `OP_ADDR` with opcode == HLT, the next state is `HALTED`. `HALTED` is left only by reset; `en` is ignored there.
- Define `aluop` = opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are combinational decodes of `state` and the inputs:
  - `mem_rd`: 1 in `INST_FETCH`, `INST_LOAD`, `IDLE`. Equals `aluop` in `OP_FETCH`, `ALU_OP`, `STORE`.
  - `load_ir`: 1 in `INST_LOAD` and `IDLE`.
  - `inc_pc`: 1 in `OP_ADDR` when opcode != HLT. Equals (opcode == SKZ && zero) in `ALU_OP`.
  - `load_ac`: `aluop` in `ALU_OP` and `STORE`.
  - `load_pc`: (opcode == JMP) in `ALU_OP` and `STORE`.
  - `data_e`: (opcode == STO) in `ALU_OP` and `STORE`.
  - `mem_wr`: (opcode == STO) in `STORE` only.
  - `halt`: 1 in `HALTED`, and also 1 in `OP_ADDR` when opcode == HLT.
- All outputs are 0 in any state not listed above for that output.
- Undefined opcode values: no strobes beyond the fetch strobes and `inc_pc` in `OP_ADDR`. The instruction behaves as a NOP.

## Timing
- Reset (async, `rst_` low): `state` = `INST_ADDR`. All strobes are then 0; `phase` = `INST_ADDR`.
- On `rst_` deassertion, the first enabled posedge moves to `INST_FETCH`.
- One instruction takes 8 enabled clocks.
- Outputs are combinational: they change in the same cycle as `state` or `opcode`/`zero`.
- `zero` is sampled only while in `ALU_OP`. The ALU updates `out` on negedge, so `load_ac` spanning `ALU_OP` and `STORE` captures a settled result.
- `en` low mid-instruction freezes `state` indefinitely; no strobe pulses twice because of a stall.
- Reset asserted in any state, including `HALTED`, returns to `INST_ADDR` immediately, without waiting for a clock edge.
- An invalid state encoding (SEU/X) recovers to `INST_ADDR` on the next posedge.

## Structure
- Add `state_t`, an enum of the 9 states, to the `typedefs` package next to `opcode_t`.
- `opcode_t` must stay the sole opcode definition.
- One module, no sub-modules. Keep the state register in `always_ff` and the next-state/output decode in `always_comb` with a `unique case`.

## Test plan
- Reset then `en`=1, opcode=LDA: `phase` walks the 8 states. `mem_rd`=1 in `INST_FETCH` through `IDLE` and `OP_FETCH` through `STORE`. `load_ac`=1 in exactly 2 cycles. `inc_pc`=1 once.
- opcode=SKZ, zero=1: `inc_pc` pulses in `OP_ADDR` and in `ALU_OP`, 2 total. With zero=0: 1 total. `load_ac`=0 throughout.
- opcode=STO: `data_e`=1 in `ALU_OP` and `STORE`. `mem_wr`=1 only in `STORE`. `mem_rd`=0 from `OP_FETCH` onward.
- opcode=JMP: `load_pc`=1 in `ALU_OP` and `STORE`. `mem_wr`=0 and `load_ac`=0 throughout.
- opcode=HLT: `halt`=1 from `OP_ADDR` onward. `phase`=`HALTED` is held for 20 clocks with `en` toggling. Pulsing `rst_` low asynchronously gives `phase`=`INST_ADDR` and `halt`=0 before the next edge.
- `en`=0 for 5 clocks in `OP_FETCH` with opcode=ADD: `phase` and `mem_rd`=1 hold. On resume the sequence finishes with `load_ac` asserted for exactly 2 enabled cycles.
